// File: rtl/eth_pkg.sv
// Shared definitions for the inter-board kart link: transmit FSM states, framing
// constants, CRC-32 parameters and the 44-bit game-state word packer.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    BODY,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam int          GAME_WORD_W   = 44;

  // Zero gaps keep each field on the bit positions the receive-side unpacker expects.
  function automatic logic [GAME_WORD_W-1:0] pack_game_word(
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [8:0]  dir,
    input logic [2:0]  game,
    input logic        reset_flag
  );
    return {x, 1'b0, y, 1'b0, dir, 3'b000, game, 1'b0, reset_flag, 3'b000};
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 (Ethernet FCS) advanced two bits per clock, bit 0 of the dibit first.
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d, step;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    step = crc_q;
    for (int i = 0; i < 2; i++) begin
      step = (step[0] ^ dibit[i]) ? ((step >> 1) ^ CRC_POLY) : (step >> 1);
    end
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = step;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/kart_state_tx.sv
// Transmit side of the kart link: snapshots player state on send_in and sends one
// RMII Ethernet frame (preamble, SFD, header, payload, pad, FCS) followed by an IFG.
module kart_state_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0242_0420_4204,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          PAD_BYTES  = 40,
  parameter int          IFG_DIBITS = 48
) (
  input  logic        eth_clk,
  input  logic        eth_rstn,
  input  logic        send_in,
  input  logic [10:0] player_x_in,
  input  logic [10:0] player_y_in,
  input  logic [8:0]  dir_in,
  input  logic [2:0]  game_stat_in,
  input  logic        reset_flag_in,
  output logic        busy_out,
  output logic        drop_out,
  output logic        done_out,
  output logic        eth_txen,
  output logic [1:0]  eth_txd
);

  localparam int HDR_BYTES   = 20;
  localparam int HDR_W       = HDR_BYTES * 8;
  localparam int PRE_DIBITS  = 32;
  localparam int BODY_DIBITS = (HDR_BYTES + PAD_BYTES) * 4;
  localparam int FCS_DIBITS  = 16;
  localparam int CNT_W       = $clog2(BODY_DIBITS > IFG_DIBITS ? BODY_DIBITS : IFG_DIBITS);

  logic                   rstn_meta_q, rstn_q;
  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAME_WORD_W-1:0] word_q, word_d;
  logic                   txen_q, busy_q, drop_q, done_q;
  logic [1:0]             txd_q;
  logic                   txen_d;
  logic [HDR_W-1:0]       hdr;
  logic [CNT_W-3:0]       byte_idx;
  logic [7:0]             tx_byte;
  logic [1:0]             dibit_d;
  logic [31:0]            crc, fcs;

  // NOTE: reset asserts asynchronously but releases two clocks later, in step with eth_clk.
  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      rstn_meta_q <= 1'b0;
      rstn_q      <= 1'b0;
    end else begin
      rstn_meta_q <= 1'b1;
      rstn_q      <= rstn_meta_q;
    end
  end

  // cnt_q indexes the dibit currently on eth_txd within its state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (send_in) begin
          state_d = PREAMBLE;
          word_d  = pack_game_word(player_x_in, player_y_in, dir_in, game_stat_in, reset_flag_in);
        end
      end
      PREAMBLE: if (cnt_q == CNT_W'(PRE_DIBITS - 1)) begin
        state_d = BODY;
        cnt_d   = '0;
      end
      BODY: if (cnt_q == CNT_W'(BODY_DIBITS - 1)) begin
        state_d = FCS;
        cnt_d   = '0;
      end
      FCS: if (cnt_q == CNT_W'(FCS_DIBITS - 1)) begin
        state_d = IFG;
        cnt_d   = '0;
      end
      IFG: if (cnt_q == CNT_W'(IFG_DIBITS - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign hdr      = {DST_MAC, SRC_MAC, ETHERTYPE, word_d, 4'b0000};
  assign byte_idx = cnt_d[CNT_W-1:2];
  assign fcs      = ~crc;
  assign txen_d   = (state_d == PREAMBLE) || (state_d == BODY) || (state_d == FCS);

  // Outputs are registered, so the mux looks at the dibit that becomes current next cycle.
  always_comb begin
    tx_byte = 8'h00;
    if (state_d == PREAMBLE) begin
      tx_byte = (int'(byte_idx) == PRE_DIBITS / 4 - 1) ? SFD_BYTE : PREAMBLE_BYTE;
    end else if (state_d == BODY) begin
      for (int i = 0; i < HDR_BYTES; i++) begin
        if (int'(byte_idx) == i) tx_byte = hdr[HDR_W-1-8*i -: 8];
      end
    end

    dibit_d = 2'b00;
    if (state_d == FCS) begin
      for (int i = 0; i < FCS_DIBITS; i++) begin
        if (int'(cnt_d[3:0]) == i) dibit_d = fcs[2*i +: 2];
      end
    end else if (txen_d) begin
      unique case (cnt_d[1:0])
        2'd0:    dibit_d = tx_byte[1:0];
        2'd1:    dibit_d = tx_byte[3:2];
        2'd2:    dibit_d = tx_byte[5:4];
        default: dibit_d = tx_byte[7:6];
      endcase
    end
  end

  // The CRC absorbs each body dibit as it is registered, so it is final when FCS starts.
  crc32_dibit u_crc (
    .clk   (eth_clk),
    .rstn  (rstn_q),
    .clear (state_q == IDLE),
    .en    (state_d == BODY),
    .dibit (dibit_d),
    .crc   (crc)
  );

  always_ff @(posedge eth_clk or negedge rstn_q) begin
    if (!rstn_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      txen_q  <= txen_d;
      txd_q   <= dibit_d;
      busy_q  <= (state_d != IDLE);
      drop_q  <= send_in && (state_q != IDLE);
      done_q  <= (state_d == FCS) && (cnt_d == CNT_W'(FCS_DIBITS - 1));
    end
  end

  assign eth_txen = txen_q;
  assign eth_txd  = txd_q;
  assign busy_out = busy_q;
  assign drop_out = drop_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_kart_state_tx.sv
// Self-checking bench for kart_state_tx: table-driven frames, corner-case sequences
// and randomized frames against a byte-level frame model with a software CRC-32.
module tb_kart_state_tx;

  typedef logic [7:0] byte_t;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  game;
    logic        rf;
    logic [47:0] payload;
  } vec_t;

  logic        eth_clk = 1'b0;
  logic        eth_rstn = 1'b1;
  logic        send_in = 1'b0;
  logic [10:0] player_x_in = '0;
  logic [10:0] player_y_in = '0;
  logic [8:0]  dir_in = '0;
  logic [2:0]  game_stat_in = '0;
  logic        reset_flag_in = 1'b0;
  logic        busy_out, drop_out, done_out, eth_txen;
  logic [1:0]  eth_txd;

  always #10 eth_clk = ~eth_clk;

  kart_state_tx dut (
    .eth_clk       (eth_clk),
    .eth_rstn      (eth_rstn),
    .send_in       (send_in),
    .player_x_in   (player_x_in),
    .player_y_in   (player_y_in),
    .dir_in        (dir_in),
    .game_stat_in  (game_stat_in),
    .reset_flag_in (reset_flag_in),
    .busy_out      (busy_out),
    .drop_out      (drop_out),
    .done_out      (done_out),
    .eth_txen      (eth_txen),
    .eth_txd       (eth_txd)
  );

  int vectors = 0;
  int miscompares = 0;
  int rel, txen_cycles, done_at, dones, drops, idle_txd_bad, busy_low_at;
  logic [1:0] cap[$];
  byte_t exp_bytes[$];
  byte_t got_bytes[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge and accumulate frame observations.
  task automatic tick();
    @(negedge eth_clk);
    rel++;
    if (eth_txen) begin
      cap.push_back(eth_txd);
      txen_cycles++;
    end else if (eth_txd != 2'b00) begin
      idle_txd_bad++;
    end
    if (done_out) begin
      dones++;
      done_at = txen_cycles;
    end
    if (drop_out) drops++;
  endtask

  function automatic logic [31:0] sw_fcs(input byte_t b[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ b[k][i]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic [47:0] model_payload(input int x, input int y, input int dir,
                                                input int game, input int rf);
    longint unsigned v;
    v = longint'(x) * (64'd1 << 37) + longint'(y) * (64'd1 << 25) + longint'(dir) * (64'd1 << 15)
      + longint'(game) * (64'd1 << 9) + longint'(rf) * (64'd1 << 7);
    return v[47:0];
  endfunction

  task automatic model_frame(input logic [47:0] payload);
    logic [31:0] f;
    byte_t hdr[14];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h42, 8'h04, 8'h20, 8'h42, 8'h04, 8'h88, 8'hB5};
    exp_bytes.delete();
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 0; i < 14; i++) exp_bytes.push_back(hdr[i]);
    for (int i = 0; i < 6; i++) exp_bytes.push_back(payload[47-8*i -: 8]);
    for (int i = 0; i < 40; i++) exp_bytes.push_back(8'h00);
    f = sw_fcs(exp_bytes[8:67]);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(f[8*i +: 8]);
  endtask

  task automatic begin_frame(input int x, input int y, input int dir, input int game, input int rf);
    player_x_in   = 11'(x);
    player_y_in   = 11'(y);
    dir_in        = 9'(dir);
    game_stat_in  = 3'(game);
    reset_flag_in = 1'(rf);
    send_in       = 1'b1;
    rel = 0; txen_cycles = 0; dones = 0; drops = 0; done_at = 0; idle_txd_bad = 0;
    cap.delete();
    tick();
    send_in = 1'b0;
    check("txen_rise", 64'(eth_txen), 64'd1);
    check("busy_rise", 64'(busy_out), 64'd1);
  endtask

  task automatic run_to_idle(input bit extra_sends);
    busy_low_at = -1;
    while (rel < 400) begin
      send_in = extra_sends && (rel == 100 || rel == 300);
      tick();
      if (!busy_out) begin
        busy_low_at = rel;
        break;
      end
    end
    send_in = 1'b0;
    check("busy_low_cycle", 64'(busy_low_at), 64'd337);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] payload, input int exp_drops);
    logic [47:0] got_pl;
    logic [31:0] got_fcs;
    int bad;
    model_frame(payload);
    got_bytes.delete();
    for (int i = 0; i < 72; i++) begin
      byte_t b = 8'h00;
      for (int d = 0; d < 4; d++) begin
        if (4*i + d < cap.size()) b[2*d +: 2] = cap[4*i+d];
      end
      got_bytes.push_back(b);
    end
    bad = 0;
    for (int i = 0; i < 68; i++) begin
      if ((i < 22 || i >= 28) && got_bytes[i] !== exp_bytes[i]) bad++;
    end
    got_pl = '0;
    for (int i = 0; i < 6; i++) got_pl[47-8*i -: 8] = got_bytes[22+i];
    got_fcs = {got_bytes[71], got_bytes[70], got_bytes[69], got_bytes[68]};
    check({tag, "_txen_len"}, 64'(txen_cycles), 64'd288);
    check({tag, "_hdr_pad_bad_bytes"}, 64'(bad), 64'd0);
    check({tag, "_payload"}, 64'(got_pl), 64'(payload));
    check({tag, "_fcs"}, 64'(got_fcs), 64'(sw_fcs(got_bytes[8:67])));
    check({tag, "_done_pos"}, 64'(done_at), 64'd288);
    check({tag, "_done_count"}, 64'(dones), 64'd1);
    check({tag, "_drops"}, 64'(drops), 64'(exp_drops));
    check({tag, "_idle_txd"}, 64'(idle_txd_bad), 64'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int x, y, d, g, r;
    logic rst_bad;

    vecs[0] = '{11'd191,  11'd191,  9'd270, 3'd1, 1'b0, 48'h17E1_7E87_0200};
    vecs[1] = '{11'd0,    11'd0,    9'd0,   3'd0, 1'b0, 48'h0000_0000_0000};
    vecs[2] = '{11'd2047, 11'd2047, 9'd359, 3'd7, 1'b1, 48'hFFEF_FEB3_8E80};
    vecs[3] = '{11'd1,    11'd0,    9'd0,   3'd0, 1'b1, 48'h0020_0000_0080};

    // Reset held while send_in toggles: nothing may come out.
    #5 eth_rstn = 1'b0;
    rel = 0; drops = 0; dones = 0; txen_cycles = 0; idle_txd_bad = 0;
    rst_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_in = ~send_in;
      tick();
      rst_bad |= eth_txen | busy_out | (eth_txd != 2'b00);
    end
    send_in = 1'b0;
    check("rst_txen", 64'(eth_txen), 64'd0);
    check("rst_txd", 64'(eth_txd), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_any_activity", 64'(rst_bad), 64'd0);
    check("rst_drops", 64'(drops), 64'd0);
    check("rst_dones", 64'(dones), 64'd0);
    eth_rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    foreach (vecs[i]) begin
      begin_frame(vecs[i].x, vecs[i].y, vecs[i].dir, vecs[i].game, vecs[i].rf);
      run_to_idle(1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].payload, 0);
      tick();
    end

    // Inputs changing right after acceptance must not reach the frame.
    begin_frame(191, 191, 270, 1, 0);
    player_x_in = 11'h7FF; player_y_in = 11'h123; dir_in = 9'd5; game_stat_in = 3'd6;
    reset_flag_in = 1'b1;
    run_to_idle(1'b0);
    check_frame("snapshot", 48'h17E1_7E87_0200, 0);
    tick();

    // Sends while busy are dropped; the first cycle with busy low accepts a new send.
    begin_frame(191, 191, 270, 1, 0);
    run_to_idle(1'b1);
    check_frame("dropped", 48'h17E1_7E87_0200, 2);
    begin_frame(300, 17, 90, 2, 1);
    run_to_idle(1'b0);
    check_frame("b2b", model_payload(300, 17, 90, 2, 1), 0);
    tick();

    for (int n = 0; n < 5; n++) begin
      x = int'($urandom_range(2047)); y = int'($urandom_range(2047));
      d = int'($urandom_range(359));  g = int'($urandom_range(7));
      r = int'($urandom_range(1));
      begin_frame(x, y, d, g, r);
      run_to_idle(1'b0);
      check_frame($sformatf("rand%0d", n), model_payload(x, y, d, g, r), 0);
      repeat (int'($urandom_range(3))) tick();
    end

    // Reset mid-frame kills the frame at once; a later send is clean.
    begin_frame(5, 6, 7, 3, 0);
    while (txen_cycles < 150 && rel < 400) tick();
    check("abort_reach_150", 64'(txen_cycles), 64'd150);
    eth_rstn = 1'b0;
    #1;
    check("abort_txen", 64'(eth_txen), 64'd0);
    check("abort_txd", 64'(eth_txd), 64'd0);
    check("abort_busy", 64'(busy_out), 64'd0);
    repeat (3) tick();
    eth_rstn = 1'b1;
    repeat (4) tick();
    check("abort_idle_busy", 64'(busy_out), 64'd0);
    x = int'($urandom_range(2047)); y = int'($urandom_range(2047)); d = int'($urandom_range(359));
    begin_frame(x, y, d, 4, 1);
    run_to_idle(1'b0);
    check_frame("post_abort", model_payload(x, y, d, 4, 1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
